// File: rtl/ctrl_pkt_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkt_pkg
//   Shared definitions for control-stream table-write packets:
//   - header field constants (flag value and bit offsets inside the 512-bit beat)
//   - control-stream widths
//   - FSM state encoding for the table-write generator
//   - ent_byte_reorder(): maps an MSB-first entry onto beat byte lanes
// ---------------------------------------------------------------------------
package ctrl_pkt_pkg;

   localparam logic [15:0] CTRL_FLAG_TBL_WR = 16'hF2F1;
   localparam int unsigned MOD_ID_LSB       = 368;
   localparam int unsigned FLAG_LSB         = 320;
   localparam int unsigned INDEX_LSB        = 384;

   localparam int unsigned AXIS_DATA_W      = 512;
   localparam int unsigned AXIS_USER_W      = 128;
   localparam int unsigned AXIS_KEEP_W      = AXIS_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      ENT  = 2'd2
   } state_t;

   // ent holds the entry right-justified (entry LSB at bit 0), nbytes is the
   // entry width in bytes. The entry's most significant byte lands in beat
   // byte 0, the next one in byte 1, and so on; lanes above nbytes stay zero.
   function automatic logic [AXIS_DATA_W-1:0] ent_byte_reorder(
      input logic [AXIS_DATA_W-1:0] ent,
      input int unsigned            nbytes
   );
      logic [AXIS_DATA_W-1:0] beat;
      logic [8:0]             src;
      logic [8:0]             dst;
      beat = '0;
      for (int unsigned i = 0; i < AXIS_KEEP_W; i++) begin
         if (i < nbytes) begin
            dst = 9'(8 * i);
            src = 9'(8 * (nbytes - 1 - i));
            beat[dst +: 8] = ent[src +: 8];
         end
      end
      return beat;
   endfunction

endpackage

// File: rtl/ctrl_tbl_wr_gen_if.sv
// ---------------------------------------------------------------------------
// ctrl_tbl_wr_gen_if
//   Control-stream AXI4-Stream bundle.
//   tdata  [512] beat payload
//   tuser  [128] sideband (tuser[15:0] carries packet length on the header)
//   tkeep  [64]  byte enables
//   tvalid/tready handshake, tlast marks the final beat of a packet
//   modport master : driver of the stream (the generator)
//   modport slave  : consumer of the stream
// ---------------------------------------------------------------------------
interface ctrl_tbl_wr_gen_if
   import ctrl_pkt_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_DATA_W,
   parameter int unsigned USER_W = AXIS_USER_W
);
   logic [DATA_W-1:0]   tdata;
   logic [USER_W-1:0]   tuser;
   logic [DATA_W/8-1:0] tkeep;
   logic                tvalid;
   logic                tlast;
   logic                tready;

   modport master (
      output tdata, tuser, tkeep, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tuser, tkeep, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/ctrl_axis_out_reg.sv
// ---------------------------------------------------------------------------
// ctrl_axis_out_reg
//   Single-stage output holding register for the control stream.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears all outputs
//   ld_i    : load the presented beat (only asserted while free_o is high)
//   tdata_i, tuser_i, tkeep_i, tlast_i : beat to load
//   free_o  : register is empty or its beat is being accepted this cycle
//   m       : control-stream master modport
//   A beat stays frozen while tvalid=1 and tready=0.
// ---------------------------------------------------------------------------
module ctrl_axis_out_reg #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned USER_W = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld_i,
   input  logic [DATA_W-1:0]   tdata_i,
   input  logic [USER_W-1:0]   tuser_i,
   input  logic [DATA_W/8-1:0] tkeep_i,
   input  logic                tlast_i,
   output logic                free_o,
   ctrl_tbl_wr_gen_if.master   m
);

   logic [DATA_W-1:0]   tdata_q;
   logic [USER_W-1:0]   tuser_q;
   logic [DATA_W/8-1:0] tkeep_q;
   logic                tlast_q;
   logic                tvalid_q;

   assign free_o = !tvalid_q || m.tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         tdata_q  <= '0;
         tuser_q  <= '0;
         tkeep_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
      end else if (ld_i) begin
         tdata_q  <= tdata_i;
         tuser_q  <= tuser_i;
         tkeep_q  <= tkeep_i;
         tlast_q  <= tlast_i;
         tvalid_q <= 1'b1;
      end else if (m.tready) begin
         tvalid_q <= 1'b0;
      end
   end

   assign m.tdata  = tdata_q;
   assign m.tuser  = tuser_q;
   assign m.tkeep  = tkeep_q;
   assign m.tlast  = tlast_q;
   assign m.tvalid = tvalid_q;

endmodule

// File: rtl/ctrl_tbl_wr_gen.sv
// ---------------------------------------------------------------------------
// ctrl_tbl_wr_gen
//   Builds table-write control packets: one header beat followed by
//   req_cnt+1 entry beats, one beat per table entry.
//   axis_clk    : clock, rising edge
//   areset      : synchronous active-high reset
//   req_valid/req_ready, req_mod_id, req_index, req_cnt : request handshake
//   ent_data/ent_valid/ent_ready : entry stream (ent_data is MSB-first)
//   ctrl_m_axis : control-stream master (tdata/tuser/tkeep/tvalid/tlast/tready)
//   busy        : FSM is not IDLE
// ---------------------------------------------------------------------------
module ctrl_tbl_wr_gen
   import ctrl_pkt_pkg::*;
#(
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_ENTRY_WIDTH        = 160
) (
   input  logic                     axis_clk,
   input  logic                     areset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [7:0]               req_mod_id,
   input  logic [7:0]               req_index,
   input  logic [4:0]               req_cnt,
   input  logic [C_ENTRY_WIDTH-1:0] ent_data,
   input  logic                     ent_valid,
   output logic                     ent_ready,
   ctrl_tbl_wr_gen_if.master        ctrl_m_axis,
   output logic                     busy
);

   localparam int unsigned KEEP_W    = C_S_AXIS_DATA_WIDTH / 8;
   localparam int unsigned ENT_BYTES = C_ENTRY_WIDTH / 8;

   state_t     state_q;
   logic [7:0] mod_id_q;
   logic [7:0] index_q;
   logic [4:0] cnt_q;
   logic [4:0] beat_cnt_q;

   logic out_free;
   logic ent_fire;
   logic last_ent;
   logic req_fire;
   logic hdr_ld;
   logic beat_ld;

   logic [C_S_AXIS_DATA_WIDTH-1:0]  ent_ext;
   logic [C_S_AXIS_DATA_WIDTH-1:0]  beat_data;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] beat_user;
   logic [KEEP_W-1:0]               beat_keep;
   logic                            beat_last;
   logic [5:0]                      hdr_beats;

   // Handshakes; everything is gated off while reset is held.
   assign ent_ready = !areset && (state_q == ENT) && out_free;
   assign ent_fire  = ent_valid && ent_ready;
   assign last_ent  = ent_fire && (beat_cnt_q == cnt_q);
   // The next request is taken in the cycle the final entry is loaded so
   // its header follows the tlast beat without a gap.
   assign req_ready = !areset && ((state_q == IDLE) || last_ent);
   assign req_fire  = req_valid && req_ready;
   assign hdr_ld    = !areset && (state_q == HDR) && out_free;
   assign beat_ld   = hdr_ld || ent_fire;
   assign busy      = (state_q != IDLE);

   assign ent_ext   = C_S_AXIS_DATA_WIDTH'(ent_data);
   // Packet length in beats: header plus cnt+1 entries.
   assign hdr_beats = 6'(cnt_q) + 6'd2;

   always_comb begin
      beat_data = '0;
      beat_user = '0;
      beat_keep = '1;
      beat_last = 1'b0;
      if (state_q == HDR) begin
         beat_data[MOD_ID_LSB +: 8]  = mod_id_q;
         beat_data[FLAG_LSB   +: 16] = CTRL_FLAG_TBL_WR;
         beat_data[INDEX_LSB  +: 8]  = index_q;
         beat_user[15:0]             = {4'b0, hdr_beats, 6'b0};
      end else begin
         beat_data = ent_byte_reorder(ent_ext, ENT_BYTES);
         beat_last = (beat_cnt_q == cnt_q);
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q    <= IDLE;
         mod_id_q   <= '0;
         index_q    <= '0;
         cnt_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_fire) begin
                  mod_id_q <= req_mod_id;
                  index_q  <= req_index;
                  cnt_q    <= req_cnt;
                  state_q  <= HDR;
               end
            end
            HDR: begin
               if (hdr_ld) begin
                  beat_cnt_q <= '0;
                  state_q    <= ENT;
               end
            end
            ENT: begin
               if (ent_fire) begin
                  beat_cnt_q <= beat_cnt_q + 5'd1;
                  if (last_ent) begin
                     if (req_fire) begin
                        mod_id_q <= req_mod_id;
                        index_q  <= req_index;
                        cnt_q    <= req_cnt;
                        state_q  <= HDR;
                     end else begin
                        state_q  <= IDLE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   ctrl_axis_out_reg #(
      .DATA_W (C_S_AXIS_DATA_WIDTH),
      .USER_W (C_S_AXIS_TUSER_WIDTH)
   ) u_out_reg (
      .clk     (axis_clk),
      .rst     (areset),
      .ld_i    (beat_ld),
      .tdata_i (beat_data),
      .tuser_i (beat_user),
      .tkeep_i (beat_keep),
      .tlast_i (beat_last),
      .free_o  (out_free),
      .m       (ctrl_m_axis)
   );

endmodule
